sync_counter: RTL
=================

# sync_counter

Parametrised synchronous counter cell: WIDTH-bit, programmable modulus, up/down/load/hold modes, with ENP/ENT cascade enables for building wider counters from identical cells. It is the first sequential member of the RV523 cell set and sits beside the combinational gates. It serves as the program-counter increment slice, the loop and timeout counters, and the building block for multi-cell counters chained through TC.

## Interface
- WIDTH, 4: counter width in bits, 1 to 16.
- MODULUS, 2**WIDTH: count range 0..MODULUS-1. Legal range is 2..2**WIDTH; any other value is an elaboration error.

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- mode  input  2  operation select: 00 hold, 01 up, 10 down, 11 load.
- enp  input  1  parallel count enable, local only.
- ent  input  1  trickle count enable, gates TC for cascade.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  counter state, registered.
- tc  output  1  terminal count, combinational, feeds the next cell's ent.
- wrap  output  1  registered one-cycle pulse after a wrap.

## Operation
- Priority at each rising clk edge: rst, then load, then count, then hold.
- rst=1: q<=0 and wrap<=0, regardless of mode, enp, ent or d.
- mode=11 (load):
  - Loads independently of enp and ent.
  - If d<=MODULUS-1, q<=d.
  - If d>=MODULUS, q<=MODULUS-1 (clamp).
  - wrap<=0.
- mode=01 (up), enp&ent=1:
  - If q==MODULUS-1, q<=0 and wrap<=1.
  - Otherwise q<=q+1 and wrap<=0.
- mode=10 (down), enp&ent=1:
  - If q==0, q<=MODULUS-1 and wrap<=1.
  - Otherwise q<=q-1 and wrap<=0.
- mode=00, or an up/down mode with enp&ent=0: q holds and wrap<=0.
- tc = ent & ((mode==01 & q==MODULUS-1) | (mode==10 & q==0)).
  - tc does not depend on enp.
  - tc is 0 in hold and load modes.
- Arithmetic is WIDTH bits, unsigned. If q is ever outside 0..MODULUS-1, the next count step moves it to 0 in up mode or to MODULUS-1 in down mode, and wrap is set.
- Cascade rules:
  - Cell k's tc drives cell k+1's ent.
  - All cells share clk, rst, mode and enp.
  - The chain counts correctly as one counter of combined modulus.

## Timing
- q: one-cycle latency from any control input to the new value; no internal pipeline.
- tc: purely combinational from q, mode and ent, valid in the same cycle.
- wrap: asserted in the cycle after the edge where the wrap occurred; lasts exactly one cycle unless another wrap follows.
- Reset values: q=0 and wrap=0. tc after reset = ent & (mode==10), since q==0.
- rst mid-count, including on a wrap edge: rst wins; wrap stays 0 and q=0.
- Load while q==MODULUS-1 in an up-mode context: the load wins, with no wrap pulse.
- Changing mode between up and down mid-count: takes effect at the next edge; no extra state.
- Single-bit case (WIDTH=1, MODULUS=2): a toggle cell; tc follows the rules above.

## Structure
- Shared package rv523_pkg holds:
  - mode constants: MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
  - a function checking that MODULUS is legal for WIDTH.
- Sub-module sync_counter_nxt:
  - combinational next-state and wrap-detect from q, mode, enp, ent and d.
  - reused by the formal model.
- sync_counter holds only the q/wrap registers, the reset and the tc decode.

## Test plan
- Reset and hold (WIDTH=4, MODULUS=10):
  - Assert rst for 2 cycles with mode=01: q=0, wrap=0.
  - Release rst with mode=00 for 5 cycles: q stays 0.
- Decade up count:
  - Set mode=01, enp=ent=1 for 12 cycles: q steps 1..9, 0, 1, 2.
  - tc=1 only while q==9.
  - wrap=1 exactly in the cycle after q goes 9 to 0.
- Down count and wrap:
  - Load d=2, then mode=10 for 4 cycles: q steps 2, 1, 0, 9, 8.
  - tc=1 while q==0.
  - wrap pulses once.
- Load clamp and priority:
  - d=13 with mode=11 and enp=ent=0: q=9.
  - Load with rst=1 in the same cycle: q=0.
  - A load on the terminal-count edge gives no wrap pulse.
- Enable gating:
  - Up mode with enp=0, ent=1: q holds, and tc is still 1 at q==9.
  - With ent=0: q holds and tc=0.
- Cascade:
  - Chain two cells (MODULUS=10) into a 0..99 counter; run 120 up cycles.
  - The combined value tracks cycle count mod 100.
  - The upper cell's wrap pulses once, at 99 to 0.

Source files
------------

// File: rtl/rv523_pkg.sv
// Shared definitions for the RV523 cell set: counter mode encodings and
// parameter legality checks.
package rv523_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // True when a counter of the given width can represent 0..modulus-1.
    function automatic bit modulus_ok(input int width, input int modulus);
        if (width < 1 || width > 16) return 1'b0;
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/sync_counter_nxt.sv
// Next-state and wrap detection for one sync_counter cell; purely combinational
// so the same logic can be shared with the formal model.
module sync_counter_nxt
    import rv523_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic             enp,
    input  logic             ent,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_nxt,
    output logic             wrap_nxt
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic cnt_en;
    assign cnt_en = enp & ent;

    // Out-of-range q is treated as a wrap so a corrupted cell recovers in one step.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        case (mode)
            MODE_LOAD: begin
                q_nxt = (d > Q_MAX) ? Q_MAX : d;
            end
            MODE_UP: begin
                if (cnt_en) begin
                    if (q >= Q_MAX) begin
                        q_nxt    = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        q_nxt = q + 1'b1;
                    end
                end
            end
            MODE_DOWN: begin
                if (cnt_en) begin
                    if ((q == '0) || (q > Q_MAX)) begin
                        q_nxt    = Q_MAX;
                        wrap_nxt = 1'b1;
                    end else begin
                        q_nxt = q - 1'b1;
                    end
                end
            end
            default: begin
                q_nxt    = q;
                wrap_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sync_counter.sv
// Cascadable WIDTH-bit counter cell with programmable modulus: state
// registers, synchronous reset and the terminal-count decode for the next cell.
module sync_counter
    import rv523_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             enp,
    input  logic             ent,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    generate
        if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
            $error("sync_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
        end
    endgenerate

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    sync_counter_nxt #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_nxt (
        .q        (q),
        .mode     (mode),
        .enp      (enp),
        .ent      (ent),
        .d        (d),
        .q_nxt    (q_nxt),
        .wrap_nxt (wrap_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

    // tc ignores enp so a stalled lower cell still reports terminal count upstream.
    assign tc = ent & (((mode == MODE_UP) & (q == Q_MAX)) |
                       ((mode == MODE_DOWN) & (q == '0)));

endmodule
